jk_counter: RTL and testbench

JK_COUNTER -- requirements
Module: jk_counter

---
 rtl/jk_counter_pkg.sv | 31 +++
 rtl/jk_counter_if.sv | 26 ++
 rtl/jk_counter_cell.sv | 26 ++
 rtl/jk_counter.sv | 102 ++++++++++
 tb/tb_jk_counter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/jk_counter_pkg.sv
// jk_pkg: mode codes, JK operation codes and the per-bit JK next-state rule
// shared by jk_counter and its jk_cell bit slices.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    RAW  = 2'b11
  } mode_e;

  // Encoded as {j, k} so a raw pin pair casts straight to its operation.
  typedef enum logic [1:0] {
    KEEP   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    jk_op_e op;
    op = jk_op_e'({j, k});
    case (op)
      KEEP:    return q;
      RESET:   return 1'b0;
      SET:     return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_counter_if.sv
// jk_counter_if: control, load data, JK pins and counter outputs between a
// driver (master) and jk_counter (slave).
interface jk_counter_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             prst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic             wrap;

  modport master (
    output clr, prst, en, load, din, mode, j, k,
    input  q, wrap
  );

  modport slave (
    input  clr, prst, en, load, din, mode, j, k,
    output q, wrap
  );
endinterface

// File: rtl/jk_counter_cell.sv
// jk_cell: one JK flip-flop bit of the counter, async active-low reset to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic state_q;
  logic state_d;

  always_comb begin
    state_d = jk_next(j, k, state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 1'b0;
    else        state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/jk_counter.sv
// jk_counter: clear/preset/load/up/down/raw-JK counter built from jk_cell bits.
// Define JK_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module jk_counter
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic        clk,
  input  logic        rst_n,
  jk_counter_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("jk_counter: WIDTH must be at least 2");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
    $error("jk_counter: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             wrap_d;
  logic             wrap_q;

  always_comb begin
    q_d    = q_cur;
    wrap_d = 1'b0;
    cell_j = '0;
    cell_k = '0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.prst) begin
      q_d = MAX_VAL;
    end else if (bus.en && bus.load) begin
      q_d = (bus.din > MAX_VAL) ? MAX_VAL : bus.din;
    end else if (bus.en) begin
      case (mode_e'(bus.mode))
        UP: begin
          if (q_cur < MAX_VAL) begin
            q_d = q_cur + WIDTH'(1);
          end else begin
`ifdef JK_COUNTER_SATURATE_EN
            q_d = MAX_VAL;
`else
            q_d = '0;
`endif
            wrap_d = 1'b1;
          end
        end
        DOWN: begin
          if (q_cur == '0) begin
`ifdef JK_COUNTER_SATURATE_EN
            q_d = '0;
`else
            q_d = MAX_VAL;
`endif
            wrap_d = 1'b1;
          end else if (q_cur > MAX_VAL) begin
            q_d = MAX_VAL;
          end else begin
            q_d = q_cur - WIDTH'(1);
          end
        end
        RAW: begin
          for (int i = 0; i < WIDTH; i++) begin
            q_d[i] = jk_next(bus.j[i], bus.k[i], q_cur[i]);
          end
        end
        default: q_d = q_cur;
      endcase
    end
    // Each cell is steered to the chosen next state: set on 0->1, reset on 1->0.
    for (int i = 0; i < WIDTH; i++) begin
      cell_j[i] = q_d[i] & ~q_cur[i];
      cell_k[i] = ~q_d[i] & q_cur[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (cell_j[g]),
      .k     (cell_k[g]),
      .q     (q_cur[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign bus.q    = q_cur;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_counter.sv
// tb_jk_counter: directed test of jk_counter (WIDTH=4, MAX_COUNT=9) against an
// arithmetic reference model, plus literal expectations; honours JK_COUNTER_SATURATE_EN.
module tb_jk_counter;

  localparam int WIDTH = 4;
  localparam int MAXC  = 9;
`ifdef JK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  jk_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatch = 0;

  int m_q    = 0;
  bit m_wrap = 1'b0;

  // Reference model: counter value as a plain integer in 0..15.
  always @(posedge clk or negedge rst_n) begin
    int jv;
    int kv;
    if (!rst_n) begin
      m_q    = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      jv = int'(bus.j);
      kv = int'(bus.k);
      if (bus.clr) m_q = 0;
      else if (bus.prst) m_q = MAXC;
      else if (bus.en && bus.load) m_q = (int'(bus.din) > MAXC) ? MAXC : int'(bus.din);
      else if (bus.en && bus.mode == 2'b01) begin
        if (m_q >= MAXC) begin
          m_q    = SAT ? MAXC : 0;
          m_wrap = 1'b1;
        end else m_q = m_q + 1;
      end else if (bus.en && bus.mode == 2'b10) begin
        if (m_q == 0) begin
          m_q    = SAT ? 0 : MAXC;
          m_wrap = 1'b1;
        end else if (m_q > MAXC) m_q = MAXC;
        else m_q = m_q - 1;
      end else if (bus.en && bus.mode == 2'b11) begin
        m_q = ((m_q & ~jv & ~kv) | (jv & ~kv) | (jv & kv & ~m_q)) & 15;
      end
    end
  end

  // Every cycle, half a period after the active edge, DUT must match the model.
  always @(negedge clk) begin
    n_compared++;
    if (bus.q !== 4'(m_q) || bus.wrap !== m_wrap) begin
      n_mismatch++;
      $display("[TB] FAIL model_cycle @%0t: q=%0d wrap=%b, expected q=%0d wrap=%b",
               $time, bus.q, bus.wrap, m_q, m_wrap);
    end
  end

  task automatic applyStimulus(input logic c, input logic p, input logic e, input logic l,
                               input logic [3:0] d, input logic [1:0] m,
                               input logic [3:0] jj, input logic [3:0] kk);
    bus.clr  = c;
    bus.prst = p;
    bus.en   = e;
    bus.load = l;
    bus.din  = d;
    bus.mode = m;
    bus.j    = jj;
    bus.k    = kk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int exp_q, input bit exp_wrap);
    n_compared++;
    if (bus.q !== 4'(exp_q) || bus.wrap !== exp_wrap) begin
      n_mismatch++;
      $display("[TB] FAIL %s: q=%0d wrap=%b, expected q=%0d wrap=%b",
               name, bus.q, bus.wrap, exp_q, exp_wrap);
    end
  endtask

  initial begin
    bus.clr = 0; bus.prst = 0; bus.en = 0; bus.load = 0;
    bus.din = '0; bus.mode = 2'b00; bus.j = '0; bus.k = '0;
    $display("[TB] start, saturate=%0b", SAT);
    #12;
    checkOutput("reset_state", 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 1, 0, 4'd0, 2'b01, 4'hF, 4'hA);
      if (SAT) checkOutput("count_up", (i < 9) ? i + 1 : 9, i >= 9);
      else     checkOutput("count_up", (i < 9) ? i + 1 : i - 9, i == 9);
    end

    applyStimulus(1, 0, 0, 0, 4'd0, 2'b01, 4'h0, 4'h0);
    checkOutput("clr_without_en", 0, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b10, 4'h0, 4'h0);
    checkOutput("down_from_zero", SAT ? 0 : 9, 1'b1);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b10, 4'h0, 4'h0);
    checkOutput("down_next", SAT ? 0 : 8, SAT);

    applyStimulus(0, 0, 1, 1, 4'd15, 2'b01, 4'h0, 4'h0);
    checkOutput("load_clamped", 9, 1'b0);
    applyStimulus(1, 1, 1, 1, 4'd5, 2'b01, 4'h0, 4'h0);
    checkOutput("clr_beats_prst", 0, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'd0, 2'b00, 4'h0, 4'h0);
    checkOutput("prst", 9, 1'b0);
    applyStimulus(0, 0, 1, 1, 4'd5, 2'b11, 4'hF, 4'hF);
    checkOutput("load_5", 5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1, 0, 4'd12, 2'b00, 4'hF, 4'h3);
      checkOutput("mode_hold", 5, 1'b0);
    end

    applyStimulus(1, 0, 1, 0, 4'd0, 2'b00, 4'h0, 4'h0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b11, 4'b1010, 4'b0000);
    checkOutput("raw_set_10", 10, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b11, 4'b0101, 4'b1001);
    checkOutput("raw_mix_7", 7, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b11, 4'b1100, 4'b0011);
    checkOutput("raw_12", 12, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b10, 4'h0, 4'h0);
    checkOutput("down_above_max", 9, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b11, 4'b1100, 4'b0011);
    checkOutput("raw_12_again", 12, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b01, 4'h0, 4'h0);
    checkOutput("up_above_max", SAT ? 9 : 0, 1'b1);

    applyStimulus(0, 0, 1, 1, 4'd3, 2'b00, 4'h0, 4'h0);
    checkOutput("load_3", 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 4'd7, 2'b01, 4'hF, 4'h0);
      checkOutput("en_low_hold", 3, 1'b0);
    end
    applyStimulus(0, 1, 0, 0, 4'd0, 2'b01, 4'h0, 4'h0);
    checkOutput("prst_en_low", 9, 1'b0);

    applyStimulus(1, 0, 0, 0, 4'd0, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 0, 4'd0, 2'b01, 4'h0, 4'h0);
    end
    checkOutput("count_to_6", 6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_cycle", 0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("restart_1", 1, 1'b0);
    applyStimulus(0, 0, 1, 0, 4'd0, 2'b01, 4'h0, 4'h0);
    checkOutput("restart_2", 2, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
